// File: rtl/matvec_seq_pkg.sv
// Shared types and constants for the sequential 3x3 matrix-by-vector multiplier.
package matvec_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRows,
        StDone
    } state_e;

    localparam int unsigned RowCntW       = 2;
    localparam int unsigned RowsPerMatrix = 3;

endpackage

// File: rtl/matvec_seq_if.sv
// Vector, row and result handshakes of matvec_seq grouped into one bundle.
interface matvec_seq_if #(
    parameter int unsigned ENTRY_SIZE    = 5,
    parameter int unsigned RESENTRY_SIZE = 9
);
    logic                     vec_valid;
    logic                     vec_ready;
    logic [ENTRY_SIZE-1:0]    b0;
    logic [ENTRY_SIZE-1:0]    b1;
    logic [ENTRY_SIZE-1:0]    b2;
    logic                     row_valid;
    logic                     row_ready;
    logic [ENTRY_SIZE-1:0]    r0;
    logic [ENTRY_SIZE-1:0]    r1;
    logic [ENTRY_SIZE-1:0]    r2;
    logic                     reuse_vec;
    logic                     res_valid;
    logic                     res_ready;
    logic [RESENTRY_SIZE-1:0] c0;
    logic [RESENTRY_SIZE-1:0] c1;
    logic [RESENTRY_SIZE-1:0] c2;
    logic                     busy;

    modport master (
        output vec_valid, b0, b1, b2, row_valid, r0, r1, r2, reuse_vec, res_ready,
        input  vec_ready, row_ready, res_valid, c0, c1, c2, busy
    );

    modport slave (
        input  vec_valid, b0, b1, b2, row_valid, r0, r1, r2, reuse_vec, res_ready,
        output vec_ready, row_ready, res_valid, c0, c1, c2, busy
    );
endinterface

// File: rtl/matvec_seq_dot.sv
// Combinational 3-element unsigned dot product, truncated to the result width.
module matvec_seq_dot #(
    parameter int unsigned ENTRY_SIZE    = 5,
    parameter int unsigned RESENTRY_SIZE = 9
) (
    input  logic [ENTRY_SIZE-1:0]    a0,
    input  logic [ENTRY_SIZE-1:0]    a1,
    input  logic [ENTRY_SIZE-1:0]    a2,
    input  logic [ENTRY_SIZE-1:0]    b0,
    input  logic [ENTRY_SIZE-1:0]    b1,
    input  logic [ENTRY_SIZE-1:0]    b2,
    output logic [RESENTRY_SIZE-1:0] dot
);

    // Working at the result width gives the modulo-2^RESENTRY_SIZE wrap for free.
    always_comb begin
        dot = RESENTRY_SIZE'(a0) * RESENTRY_SIZE'(b0)
            + RESENTRY_SIZE'(a1) * RESENTRY_SIZE'(b1)
            + RESENTRY_SIZE'(a2) * RESENTRY_SIZE'(b2);
    end

endmodule

// File: rtl/matvec_seq.sv
// Sequential 3x3 matrix-by-vector multiplier: latch b, dot each incoming row of A
// with it, then present c = A*b on a valid/ready result port.
module matvec_seq
    import matvec_seq_pkg::*;
#(
    parameter int unsigned ENTRY_SIZE    = 5,
    parameter int unsigned RESENTRY_SIZE = 9
) (
    input logic          clk,
    input logic          reset,
    matvec_seq_if.slave  bus
);

    state_e                   state_q, state_d;
    logic [RowCntW-1:0]       cnt_q, cnt_d;
    logic [ENTRY_SIZE-1:0]    b_q [RowsPerMatrix];
    logic [ENTRY_SIZE-1:0]    b_d [RowsPerMatrix];
    logic [RESENTRY_SIZE-1:0] c_q [RowsPerMatrix];
    logic [RESENTRY_SIZE-1:0] c_d [RowsPerMatrix];
    logic [RESENTRY_SIZE-1:0] dot_res;

    matvec_seq_dot #(
        .ENTRY_SIZE    (ENTRY_SIZE),
        .RESENTRY_SIZE (RESENTRY_SIZE)
    ) u_dot (
        .a0  (bus.r0),
        .a1  (bus.r1),
        .a2  (bus.r2),
        .b0  (b_q[0]),
        .b1  (b_q[1]),
        .b2  (b_q[2]),
        .dot (dot_res)
    );

    // Handshake outputs depend on state only, never on inputs.
    assign bus.vec_ready = (state_q == StIdle);
    assign bus.row_ready = (state_q == StRows);
    assign bus.res_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.c0        = c_q[0];
    assign bus.c1        = c_q[1];
    assign bus.c2        = c_q[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        c_d     = c_q;

        unique case (state_q)
            StIdle: begin
                if (bus.vec_valid) begin
                    b_d[0]  = bus.b0;
                    b_d[1]  = bus.b1;
                    b_d[2]  = bus.b2;
                    cnt_d   = '0;
                    state_d = StRows;
                end
            end
            StRows: begin
                if (bus.row_valid) begin
                    for (int i = 0; i < RowsPerMatrix; i++) begin
                        if (cnt_q == RowCntW'(i)) c_d[i] = dot_res;
                    end
                    if (cnt_q == RowCntW'(RowsPerMatrix - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = bus.reuse_vec ? StRows : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < RowsPerMatrix; i++) begin
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_matvec_seq.sv
// Self-checking bench for matvec_seq: directed scenarios plus randomized matrices
// compared against a plain-arithmetic model of c = A*b mod 2^9.
module tb_matvec_seq;

    localparam int unsigned Ew = 5;
    localparam int unsigned Rw = 9;

    logic clk;
    logic reset;

    matvec_seq_if #(.ENTRY_SIZE(Ew), .RESENTRY_SIZE(Rw)) bus ();

    matvec_seq #(.ENTRY_SIZE(Ew), .RESENTRY_SIZE(Rw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int mat_a [3][3];
    int model_b [3];

    function automatic int unsigned ref_c(input int i);
        int unsigned s = 0;
        for (int j = 0; j < 3; j++) s += mat_a[i][j] * model_b[j];
        return s % 512;
    endfunction

    function automatic int unsigned c_out(input int i);
        if (i == 0) return int'(bus.c0);
        if (i == 1) return int'(bus.c1);
        return int'(bus.c2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_diag(input int k);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) mat_a[i][j] = (i == j) ? k : 0;
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (bus.vec_ready !== 1'b1 || bus.row_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle flags: vr=%b rr=%b rv=%b busy=%b, need 1 0 0 0", tag,
                     bus.vec_ready, bus.row_ready, bus.res_valid, bus.busy);
        end
    endtask

    task automatic send_vec(input int x0, input int x1, input int x2);
        int n = 0;
        bus.b0 = Ew'(x0);
        bus.b1 = Ew'(x1);
        bus.b2 = Ew'(x2);
        bus.vec_valid = 1'b1;
        while (bus.vec_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (bus.vec_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL vec_timeout: vec_ready=%b after %0d cycles, need 1", bus.vec_ready, n);
        end
        step();
        bus.vec_valid = 1'b0;
        model_b[0] = x0;
        model_b[1] = x1;
        model_b[2] = x2;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.row_ready !== 1'b1 || bus.vec_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL after_vec: busy=%b rr=%b vr=%b, need 1 1 0", bus.busy,
                     bus.row_ready, bus.vec_ready);
        end
    endtask

    task automatic send_row(input int i);
        int n = 0;
        bus.r0 = Ew'(mat_a[i][0]);
        bus.r1 = Ew'(mat_a[i][1]);
        bus.r2 = Ew'(mat_a[i][2]);
        bus.row_valid = 1'b1;
        while (bus.row_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (bus.row_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL row_timeout: row_ready=%b after %0d cycles, need 1", bus.row_ready, n);
        end
        step();
        bus.row_valid = 1'b0;
    endtask

    // Rows of mat_a against model_b, optional gaps/vec pokes, backpressure, then result.
    task automatic run_matrix(input int gap, input int hold, input bit reuse, input bit poke);
        int unsigned exp_c [3];
        int unsigned snap [3];
        for (int i = 0; i < 3; i++) begin
            send_row(i);
            if (i < 2) begin
                for (int g = 0; g < gap; g++) begin
                    if (poke && g == 0) begin
                        bus.b0 = 5'd7;
                        bus.b1 = 5'd7;
                        bus.b2 = 5'd7;
                        bus.vec_valid = 1'b1;
                    end
                    n_cmp++;
                    if (bus.vec_ready !== 1'b0 || bus.row_ready !== 1'b1 ||
                        bus.res_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL gap_flags: vr=%b rr=%b rv=%b, need 0 1 0",
                                 bus.vec_ready, bus.row_ready, bus.res_valid);
                    end
                    step();
                    bus.vec_valid = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++) exp_c[i] = ref_c(i);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.row_ready !== 1'b0 || bus.vec_ready !== 1'b0 ||
            bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL res_latency: rv=%b rr=%b vr=%b busy=%b, need 1 0 0 1",
                     bus.res_valid, bus.row_ready, bus.vec_ready, bus.busy);
        end
        for (int i = 0; i < 3; i++) snap[i] = c_out(i);
        for (int h = 0; h < hold; h++) begin
            step();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.row_ready !== 1'b0 || bus.vec_ready !== 1'b0 ||
                c_out(0) != snap[0] || c_out(1) != snap[1] || c_out(2) != snap[2]) begin
                n_bad++;
                $display("FAIL backpressure cyc %0d: rv=%b rr=%b vr=%b c=(%0d,%0d,%0d) need 1 0 0 (%0d,%0d,%0d)",
                         h, bus.res_valid, bus.row_ready, bus.vec_ready, c_out(0), c_out(1),
                         c_out(2), snap[0], snap[1], snap[2]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (c_out(i) != exp_c[i]) begin
                n_bad++;
                $display("FAIL c%0d: got %0d expected %0d", i, c_out(i), exp_c[i]);
            end
        end
        bus.res_ready = 1'b1;
        bus.reuse_vec = reuse;
        step();
        bus.res_ready = 1'b0;
        bus.reuse_vec = 1'b0;
        n_cmp++;
        if (reuse) begin
            if (bus.row_ready !== 1'b1 || bus.vec_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
                bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL post_reuse: rr=%b vr=%b rv=%b busy=%b, need 1 0 0 1",
                         bus.row_ready, bus.vec_ready, bus.res_valid, bus.busy);
            end
        end else if (bus.vec_ready !== 1'b1 || bus.row_ready !== 1'b0 ||
                     bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_result: vr=%b rr=%b rv=%b busy=%b, need 1 0 0 0",
                     bus.vec_ready, bus.row_ready, bus.res_valid, bus.busy);
        end
        n_cmp++;
        if (c_out(0) != exp_c[0] || c_out(1) != exp_c[1] || c_out(2) != exp_c[2]) begin
            n_bad++;
            $display("FAIL c_hold: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", c_out(0),
                     c_out(1), c_out(2), exp_c[0], exp_c[1], exp_c[2]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        check_idle("reset");
        n_cmp++;
        if (bus.c0 !== 9'd0 || bus.c1 !== 9'd0 || bus.c2 !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_c: got (%0d,%0d,%0d) expected (0,0,0)", bus.c0, bus.c1, bus.c2);
        end
        reset = 1'b0;
    endtask

    task automatic test_identity();
        set_diag(1);
        send_vec(1, 2, 3);
        run_matrix(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) mat_a[i][j] = 31;
        send_vec(31, 31, 31);
        run_matrix(0, 0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.c0 !== 9'd323) begin
            n_bad++;
            $display("FAIL wrap_c0: got %0d expected 323", bus.c0);
        end
    endtask

    task automatic test_backpressure();
        set_diag(1);
        send_vec(1, 2, 3);
        run_matrix(0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reuse();
        set_diag(1);
        send_vec(1, 2, 3);
        run_matrix(0, 0, 1'b1, 1'b0);
        set_diag(2);
        run_matrix(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        set_diag(1);
        send_vec(1, 2, 3);
        run_matrix(1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        set_diag(1);
        send_vec(1, 2, 3);
        send_row(0);
        send_row(1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("reset_mid");
        n_cmp++;
        if (bus.c0 !== 9'd0 || bus.c1 !== 9'd0 || bus.c2 !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_mid_c: got (%0d,%0d,%0d) expected (0,0,0)", bus.c0, bus.c1,
                     bus.c2);
        end
        test_identity();
    endtask

    task automatic test_random();
        bit have_vec = 1'b0;
        for (int t = 0; t < 25; t++) begin
            bit reuse;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) mat_a[i][j] = int'($urandom_range(31, 0));
            if (!have_vec)
                send_vec(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                         int'($urandom_range(31, 0)));
            reuse = ($urandom_range(1, 0) == 1) && (t != 24);
            run_matrix(int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), reuse,
                       $urandom_range(1, 0) == 1);
            have_vec = reuse;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.vec_valid = 1'b0;
        bus.row_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.reuse_vec = 1'b0;
        bus.b0 = '0;
        bus.b1 = '0;
        bus.b2 = '0;
        bus.r0 = '0;
        bus.r1 = '0;
        bus.r2 = '0;
        test_reset();
        test_identity();
        test_wrap();
        test_backpressure();
        test_reuse();
        test_gapped();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
